// File: rtl/uart_tx_tick_if.sv
// Byte handshake between a data source and the uart_tx_tick transmitter.
// The source drives tx_data/tx_valid and the transmitter answers with tx_ready.
interface uart_tx_tick_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  // Data source side.
  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  // Transmitter side.
  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/uart_tx_tick.sv
// UART transmitter paced by the clock-divider output level on baud_in.
// A rising edge of baud_in forms a one-cycle tick. Each tick advances the line by one bit period.
// The frame is start, DATA_BITS data bits (LSB first), an optional parity bit, then STOP_BITS stop
// bits.
// Optional feature: define UART_TX_PARITY_EN to add an even-parity bit after the MSB.
module uart_tx_tick #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic           clkin,
  input  logic           rst,
  input  logic           baud_in,
  uart_tx_tick_if.slave  tx,
  output logic           txd,
  output logic           busy
);

  localparam logic [3:0] LastBit  = 4'(DATA_BITS - 1);
  localparam logic       LastStop = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StSync  = 3'd1,
    StStart = 3'd2,
    StData  = 3'd3,
`ifdef UART_TX_PARITY_EN
    StStop  = 3'd4,
    StParity = 3'd5
`else
    StStop  = 3'd4
`endif
  } state_e;

  state_e               state_q, state_d;
  logic                 txd_q, txd_d;
  logic                 busy_q, busy_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [3:0]           bitcnt_q, bitcnt_d;
  logic                 stopcnt_q, stopcnt_d;
  logic                 baud_q;
  logic                 tick;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  // Rising edge of the divider level; baud_q resets high so a high level at release is no tick.
  assign tick = baud_in & ~baud_q;

  assign tx.tx_ready = (state_q == StIdle);
  assign txd         = txd_q;
  assign busy        = busy_q;

  // Next-state and next-line-level decode; every transition except the accept waits for a tick.
  always_comb begin
    state_d   = state_q;
    txd_d     = txd_q;
    shift_d   = shift_q;
    bitcnt_d  = bitcnt_q;
    stopcnt_d = stopcnt_q;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    unique case (state_q)
      StIdle: begin
        txd_d = 1'b1;
        if (tx.tx_valid) begin
          state_d = StSync;
          shift_d = tx.tx_data;
`ifdef UART_TX_PARITY_EN
          parity_d = ^tx.tx_data;
`endif
        end
      end
      // Wait for a tick so the start bit is a full period long.
      StSync: begin
        if (tick) begin
          state_d = StStart;
          txd_d   = 1'b0;
        end
      end
      StStart: begin
        if (tick) begin
          state_d  = StData;
          txd_d    = shift_q[0];
          bitcnt_d = 4'd0;
        end
      end
      StData: begin
        if (tick) begin
          if (bitcnt_q == LastBit) begin
            stopcnt_d = 1'b0;
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
            txd_d   = parity_q;
`else
            state_d = StStop;
            txd_d   = 1'b1;
`endif
          end else begin
            shift_d  = shift_q >> 1;
            txd_d    = shift_d[0];
            bitcnt_d = bitcnt_q + 4'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (tick) begin
          state_d   = StStop;
          txd_d     = 1'b1;
          stopcnt_d = 1'b0;
        end
      end
`endif
      StStop: begin
        txd_d = 1'b1;
        if (tick) begin
          if (stopcnt_q == LastStop) begin
            state_d   = StIdle;
            stopcnt_d = 1'b0;
          end else begin
            stopcnt_d = stopcnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        txd_d   = 1'b1;
      end
    endcase
    busy_d = (state_d != StIdle);
  end

  // State, line and datapath registers with synchronous reset that drops any frame in flight.
  always_ff @(posedge clkin) begin
    if (rst) begin
      state_q   <= StIdle;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
      shift_q   <= '0;
      bitcnt_q  <= 4'd0;
      stopcnt_q <= 1'b0;
      baud_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      txd_q     <= txd_d;
      busy_q    <= busy_d;
      shift_q   <= shift_d;
      bitcnt_q  <= bitcnt_d;
      stopcnt_q <= stopcnt_d;
      baud_q    <= baud_in;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_tick.sv
// Self-checking bench for uart_tx_tick with a DIV=4 divider model driving baud_in.
// Expected frames are hand-computed constants; UART_TX_PARITY_EN selects the parity variants.
module tb_uart_tx_tick;
  localparam int unsigned DIV = 4;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned NBITS = 11;
`else
  localparam int unsigned NBITS = 10;
`endif

  logic clkin = 1'b0;
  logic rst = 1'b1;
  logic baud_in = 1'b1;
  logic txd;
  logic busy;

  uart_tx_tick_if #(.DATA_BITS(8)) tx ();

  uart_tx_tick #(
    .DATA_BITS(8),
    .STOP_BITS(1)
  ) dut (
    .clkin  (clkin),
    .rst    (rst),
    .baud_in(baud_in),
    .tx     (tx),
    .txd    (txd),
    .busy   (busy)
  );

  always #5 clkin = ~clkin;

  int checks = 0;
  int errors = 0;
  int bcnt = 0;
  bit baud_run = 1'b1;

  typedef struct {
    logic [7:0]  data;
    logic [11:0] exp;  // bit i = i-th transmitted bit
  } vec_t;

  vec_t vt[7];
  localparam int IA5 = 0, I00 = 1, IFF = 2, I5A = 3, I81 = 4, I3C = 5, I07 = 6;

  // Advance one clock; drive the divider level just after the edge.
  task automatic step();
    @(posedge clkin);
    #1;
    if (baud_run) begin
      bcnt = (bcnt + 1) % DIV;
      baud_in = (bcnt >= DIV / 2);
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting, got no event expected event", name);
  endtask

  // Present a byte and wait (bounded) for the accepting edge.
  task automatic accept(input string name, input logic [7:0] d, input bit keep);
    bit done = 1'b0;
    tx.tx_data  = d;
    tx.tx_valid = 1'b1;
    for (int i = 0; i < 30 * DIV; i++) begin
      if (tx.tx_ready === 1'b1) begin
        step();
        done = 1'b1;
        break;
      end
      step();
    end
    if (!keep) tx.tx_valid = 1'b0;
    if (!done) timeout({name, " accept"});
    else begin
      check({name, " busy after accept"}, busy, 1);
      check({name, " ready after accept"}, tx.tx_ready, 0);
    end
  endtask

  task automatic wait_start(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3 * DIV; i++) begin
      if (txd === 1'b0) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) timeout({name, " start bit"});
  endtask

  // Record a whole frame from the start-bit edge and compare every cycle of every bit.
  task automatic capture(input string name, input logic [11:0] exp, input int inj);
    logic       smp[NBITS*DIV];
    logic [3:0] got4;
    bit         ok;
    wait_start(name, ok);
    if (!ok) return;
    for (int k = 0; k < NBITS * DIV; k++) begin
      smp[k] = txd;
      if (inj >= 0 && k == inj) begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = 8'h3C;
      end else if (inj >= 0 && k == inj + 1) begin
        tx.tx_valid = 1'b0;
        check({name, " ready mid-frame"}, tx.tx_ready, 0);
      end
      if (k == NBITS * DIV - 1) check({name, " ready before last tick"}, tx.tx_ready, 0);
      step();
    end
    for (int i = 0; i < NBITS; i++) begin
      for (int j = 0; j < DIV; j++) got4[j] = smp[i*DIV+j];
      check($sformatf("%s bit%0d", name, i), got4, {4{exp[i]}});
    end
    check({name, " ready after stop tick"}, tx.tx_ready, 1);
    check({name, " busy after stop tick"}, busy, 0);
    check({name, " txd idle"}, txd, 1);
  endtask

  initial begin
`ifdef UART_TX_PARITY_EN
    vt[IA5] = '{8'hA5, 12'h54A};
    vt[I00] = '{8'h00, 12'h400};
    vt[IFF] = '{8'hFF, 12'h5FE};
    vt[I5A] = '{8'h5A, 12'h4B4};
    vt[I81] = '{8'h81, 12'h502};
    vt[I3C] = '{8'h3C, 12'h478};
    vt[I07] = '{8'h07, 12'h60E};
`else
    vt[IA5] = '{8'hA5, 12'h34A};
    vt[I00] = '{8'h00, 12'h200};
    vt[IFF] = '{8'hFF, 12'h3FE};
    vt[I5A] = '{8'h5A, 12'h2B4};
    vt[I81] = '{8'h81, 12'h302};
    vt[I3C] = '{8'h3C, 12'h278};
    vt[I07] = '{8'h07, 12'h20E};
`endif

    // Reset with baud toggling and tx_valid high: stays idle.
    rst = 1'b1;
    tx.tx_valid = 1'b1;
    tx.tx_data  = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      step();
      check("reset txd", txd, 1);
      check("reset busy", busy, 0);
      check("reset ready", tx.tx_ready, 1);
    end
    rst = 1'b0;
    tx.tx_valid = 1'b0;
    for (int i = 0; i < 2 * DIV; i++) begin
      step();
      check("idle txd", txd, 1);
      check("idle ready", tx.tx_ready, 1);
    end

    // Table of standalone frames.
    for (int i = 0; i < 7; i++) begin
      accept($sformatf("vec%0d", i), vt[i].data, 1'b0);
      capture($sformatf("vec%0d", i), vt[i].exp, -1);
      for (int j = 0; j < i % 3; j++) step();
    end

    // Back-to-back with tx_valid held; data changes mid-frame and is not re-sampled.
    accept("b2b", vt[I00].data, 1'b1);
    tx.tx_data = vt[IFF].data;
    capture("b2b first", vt[I00].exp, -1);
    step();
    check("b2b second accepted busy", busy, 1);
    check("b2b second accepted ready", tx.tx_ready, 0);
    tx.tx_valid = 1'b0;
    capture("b2b second", vt[IFF].exp, -1);

    // tx_valid pulse during DATA is ignored.
    accept("ignore", vt[I5A].data, 1'b0);
    capture("ignore", vt[I5A].exp, 4 * DIV + 1);
    for (int i = 0; i < 3 * DIV; i++) step();
    check("ignore no second frame txd", txd, 1);
    check("ignore no second frame busy", busy, 0);

    // Reset during data bit 3 drops the frame; the next frame is intact.
    begin
      bit ok;
      accept("midrst", vt[IA5].data, 1'b0);
      wait_start("midrst", ok);
      if (ok) begin
        for (int i = 0; i < 4 * DIV + 1; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst txd", txd, 1);
        check("midrst busy", busy, 0);
        check("midrst ready", tx.tx_ready, 1);
      end
      accept("after rst", vt[I81].data, 1'b0);
      capture("after rst", vt[I81].exp, -1);
    end

    // Divider stuck high: no ticks, block holds in SYNC with txd high.
    begin
      bit held = 1'b1;
      baud_run = 1'b0;
      baud_in  = 1'b1;
      accept("stuck", vt[I3C].data, 1'b0);
      for (int i = 0; i < 5 * DIV; i++) begin
        step();
        if (txd !== 1'b1 || busy !== 1'b1 || tx.tx_ready !== 1'b0) held = 1'b0;
      end
      check("stuck holds", held, 1);
      baud_run = 1'b1;
      capture("stuck resume", vt[I3C].exp, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected summary");
    $fatal(1);
  end

endmodule
